// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned WD_W   = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IF  = 2'd1,
        GRANT_MEM = 2'd2,
        ACK       = 2'd3
    } state_t;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Transfer fields held on the bus for the whole granted transaction
    typedef struct packed {
        logic              we;
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle counter that flags a transfer hung for LIMIT bus cycles without completion.
module bus_watchdog
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    logic [WD_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WD_W'(1);
        end
    end

    // Expires on the cycle whose increment would reach LIMIT
    assign expired_c = enable && (count == WD_W'(LIMIT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch and load/store, with a hang watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              timeout_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o
);

    state_t            state, state_nx;
    logic              last_grant, last_grant_nx;
    bus_cmd_t          cmd, cmd_nx;
    logic              bus_req_nx;
    logic              if_ack_nx, mem_ack_nx, timeout_nx;
    logic [DATA_W-1:0] if_data_nx, mem_rdata_nx;
    logic              wd_clear, wd_en, wd_expired;

    bus_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst),
        .clear     (wd_clear),
        .enable    (wd_en),
        .expired_c (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= GNT_IF;
            cmd         <= '0;
            bus_req_o   <= 1'b0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_nx;
            last_grant  <= last_grant_nx;
            cmd         <= cmd_nx;
            bus_req_o   <= bus_req_nx;
            if_ack_o    <= if_ack_nx;
            mem_ack_o   <= mem_ack_nx;
            if_data_o   <= if_data_nx;
            mem_rdata_o <= mem_rdata_nx;
            timeout_o   <= timeout_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        cmd_nx        = cmd;
        bus_req_nx    = bus_req_o;
        if_ack_nx     = 1'b0;
        mem_ack_nx    = 1'b0;
        if_data_nx    = '0;
        mem_rdata_nx  = '0;
        timeout_nx    = 1'b0;
        wd_clear      = 1'b0;
        wd_en         = 1'b0;

        case (state)
            IDLE: begin
                // Data wins a tie only when fetch held the previous grant
                if (mem_req_i && (!if_req_i || last_grant == GNT_IF)) begin
                    state_nx      = GRANT_MEM;
                    last_grant_nx = GNT_MEM;
                    cmd_nx.we     = mem_we_i;
                    cmd_nx.sel    = mem_sel_i;
                    cmd_nx.addr   = mem_addr_i;
                    cmd_nx.wdata  = mem_wdata_i;
                    bus_req_nx    = 1'b1;
                    wd_clear      = 1'b1;
                end else if (if_req_i) begin
                    state_nx      = GRANT_IF;
                    last_grant_nx = GNT_IF;
                    cmd_nx.we     = 1'b0;
                    cmd_nx.sel    = '1;
                    cmd_nx.addr   = if_addr_i;
                    cmd_nx.wdata  = '0;
                    bus_req_nx    = 1'b1;
                    wd_clear      = 1'b1;
                end
            end
            GRANT_IF, GRANT_MEM: begin
                wd_en = !bus_ack_i;
                // A slave ack on the expiry cycle still completes normally
                if (bus_ack_i || wd_expired) begin
                    state_nx   = ACK;
                    bus_req_nx = 1'b0;
                    cmd_nx     = '0;
                    timeout_nx = !bus_ack_i;
                    if (state == GRANT_IF) begin
                        if_ack_nx  = 1'b1;
                        if_data_nx = bus_ack_i ? bus_rdata_i : '0;
                    end else begin
                        mem_ack_nx   = 1'b1;
                        mem_rdata_nx = bus_ack_i ? bus_rdata_i : '0;
                    end
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus_we_o    = cmd.we;
    assign bus_sel_o   = cmd.sel;
    assign bus_addr_o  = cmd.addr;
    assign bus_wdata_o = cmd.wdata;

    assign stallreq_if_o  = if_req_i & ~if_ack_o;
    assign stallreq_mem_o = mem_req_i & ~mem_ack_o;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a delay-programmable slave model plus a short-timeout instance.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int unsigned TO_SHORT = 4;

    typedef struct packed {
        logic        is_mem;
        logic [31:0] data;
        logic        to;
    } ack_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_data, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_req, bus_we, timeout, stall_if, stall_mem;
    logic [3:0]  bus_sel;

    logic        t_mem_req, t_bus_ack;
    logic [31:0] t_rdata;
    logic [31:0] t_if_data, t_mem_rdata, t_bus_addr, t_bus_wdata;
    logic        t_if_ack, t_mem_ack, t_bus_req, t_bus_we, t_timeout, t_stall_if, t_stall_mem;
    logic [3:0]  t_bus_sel;

    int          n_checks = 0;
    int          n_errors = 0;
    int          slave_delay = 1;
    ack_exp_t    exp_q[$];
    bus_cmd_t    bus_q[$];

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata), .bus_ack_i(bus_ack),
        .timeout_o(timeout), .stallreq_if_o(stall_if), .stallreq_mem_o(stall_mem)
    );

    bus_arbiter #(.TIMEOUT_CYCLES(TO_SHORT)) dut_to (
        .clk(clk), .rst(rst),
        .if_req_i(1'b0), .if_addr_i(if_addr), .if_data_o(t_if_data), .if_ack_o(t_if_ack),
        .mem_req_i(t_mem_req), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_rdata_o(t_mem_rdata), .mem_ack_o(t_mem_ack),
        .bus_req_o(t_bus_req), .bus_we_o(t_bus_we), .bus_sel_o(t_bus_sel), .bus_addr_o(t_bus_addr),
        .bus_wdata_o(t_bus_wdata), .bus_rdata_i(t_rdata), .bus_ack_i(t_bus_ack),
        .timeout_o(t_timeout), .stallreq_if_o(t_stall_if), .stallreq_mem_o(t_stall_mem)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h3401_1100 : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus_cmd_t c;
        ack_exp_t e;
        if_req  = 1'b1;
        if_addr = a;
        c.we = 1'b0; c.sel = 4'hF; c.addr = a; c.wdata = 32'h0;
        bus_q.push_back(c);
        e.is_mem = 1'b0; e.data = slave_word(a); e.to = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic mem_txn(input logic we, input logic [3:0] sel, input logic [31:0] a,
                           input logic [31:0] wd, input logic want_ack);
        bus_cmd_t c;
        ack_exp_t e;
        mem_req = 1'b1; mem_we = we; mem_sel = sel; mem_addr = a; mem_wdata = wd;
        c.we = we; c.sel = sel; c.addr = a; c.wdata = wd;
        bus_q.push_back(c);
        if (want_ack) begin
            e.is_mem = 1'b1; e.data = slave_word(a); e.to = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Returns at the falling edge of the cycle in which either ack is high
    task automatic wait_ack(output logic is_mem);
        is_mem = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (if_ack || mem_ack) begin
                is_mem = mem_ack;
                return;
            end
        end
        check("ack_wait_expired", 32'd0, 32'd1);
    endtask

    // Slave: acks the slave_delay-th cycle of a strobe; 0 means never ack
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req) begin
                wait_cnt++;
                if (slave_delay != 0 && wait_cnt == slave_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = slave_word(bus_addr);
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = 32'hFFFF_FFFF;
                end
            end else begin
                wait_cnt  = 0;
                bus_ack   = 1'b0;
                bus_rdata = 32'h0;
            end
        end
    end

    // Monitor: bus fields against the expected command, acks against the scoreboard
    initial begin
        logic     prev_req;
        bus_cmd_t cur;
        ack_exp_t e;
        prev_req = 1'b0;
        cur      = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus_req) begin
                    if (!prev_req) begin
                        check("bus_q_avail", 32'(bus_q.size() != 0), 32'd1);
                        if (bus_q.size() != 0) cur = bus_q.pop_front();
                    end
                    check("bus_we", 32'(bus_we), 32'(cur.we));
                    check("bus_sel", 32'(bus_sel), 32'(cur.sel));
                    check("bus_addr", bus_addr, cur.addr);
                    check("bus_wdata", bus_wdata, cur.wdata);
                end
                if (if_ack || mem_ack) begin
                    check("ack_onehot", 32'(if_ack & mem_ack), 32'd0);
                    check("ack_q_avail", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("ack_master", 32'(mem_ack), 32'(e.is_mem));
                        check("ack_data", mem_ack ? mem_rdata : if_data, e.data);
                        check("ack_timeout", 32'(timeout), 32'(e.to));
                    end
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        logic m;
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        t_mem_req = 1'b0; t_bus_ack = 1'b0; t_rdata = 32'h0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        rst = 1'b1;

        // Single fetch, slave acks in cycle 1
        tick();
        fetch(32'h0000_0100);
        @(negedge clk);
        check("f_c0_stall", 32'(stall_if), 32'd1);
        check("f_c0_bus_req", 32'(bus_req), 32'd0);
        tick();
        @(negedge clk);
        check("f_c1_bus_req", 32'(bus_req), 32'd1);
        check("f_c1_addr", bus_addr, 32'h0000_0100);
        check("f_c1_stall", 32'(stall_if), 32'd1);
        tick();
        @(negedge clk);
        check("f_c2_ack", 32'(if_ack), 32'd1);
        check("f_c2_data", if_data, 32'h3401_1100);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("f_c3_ack", 32'(if_ack), 32'd0);

        // Fresh reset, then simultaneous requests held high: data first, then strict alternation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        mem_txn(1'b1, 4'hF, 32'h8000_0000, 32'hDEAD_BEEF, 1'b1);
        fetch(32'h0000_0104);
        tick();
        @(negedge clk);
        check("tie_we", 32'(bus_we), 32'd1);
        check("tie_addr", bus_addr, 32'h8000_0000);
        for (int n = 0; n < 6; n++) begin
            wait_ack(m);
            check("alt_order", 32'(m), (n % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            if (n < 5) begin
                if (m) mem_txn(1'(n % 2), 4'hF, 32'h8000_0010 + 32'(n) * 32'd4, 32'h1000 + 32'(n), 1'b1);
                else   fetch(32'h0000_0108 + 32'(n) * 32'd4);
            end else begin
                if (m) mem_req = 1'b0;
                else   if_req = 1'b0;
            end
        end
        wait_ack(m);
        check("alt_last", 32'(m), 32'd1);
        tick();
        mem_req = 1'b0;
        check("alt_q_empty", 32'(exp_q.size()), 32'd0);

        // Slow slave: load acked in cycle 5
        slave_delay = 5;
        tick();
        mem_txn(1'b0, 4'h3, 32'h0000_2000, 32'h1111_2222, 1'b1);
        @(negedge clk);
        check("slow_c0_stall", 32'(stall_mem), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            @(negedge clk);
            check("slow_req", 32'(bus_req), 32'd1);
            check("slow_no_ack", 32'(mem_ack), 32'd0);
        end
        tick();
        @(negedge clk);
        check("slow_c6_ack", 32'(mem_ack), 32'd1);
        check("slow_c6_req", 32'(bus_req), 32'd0);
        tick();
        mem_req = 1'b0;
        @(negedge clk);
        check("slow_c7_ack", 32'(mem_ack), 32'd0);
        slave_delay = 1;

        // Back-to-back fetches with req held through ack
        tick();
        fetch(32'h0000_0200);
        wait_ack(m);
        check("b2b_first", 32'(m), 32'd0);
        tick();
        fetch(32'h0000_0204);
        @(negedge clk);
        check("b2b_gap", 32'(bus_req), 32'd0);
        tick();
        @(negedge clk);
        check("b2b_restart", 32'(bus_req), 32'd1);
        check("b2b_addr", bus_addr, 32'h0000_0204);
        wait_ack(m);
        check("b2b_second", 32'(m), 32'd0);
        tick();
        if_req = 1'b0;

        // Reset during a data transfer that never completes
        slave_delay = 0;
        tick();
        mem_txn(1'b0, 4'hF, 32'h0000_4000, 32'h0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("rmid_pre_req", 32'(bus_req), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rmid_bus_req", 32'(bus_req), 32'd0);
        check("rmid_mem_ack", 32'(mem_ack), 32'd0);
        check("rmid_if_ack", 32'(if_ack), 32'd0);
        check("rmid_addr", bus_addr, 32'd0);
        mem_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        slave_delay = 1;
        tick();
        mem_txn(1'b1, 4'hF, 32'h8000_0040, 32'h0BAD_F00D, 1'b1);
        fetch(32'h0000_0300);
        wait_ack(m);
        check("rst_tie_mem", 32'(m), 32'd1);
        tick();
        mem_req = 1'b0;
        wait_ack(m);
        check("rst_tie_if", 32'(m), 32'd0);
        tick();
        if_req = 1'b0;

        // Short-timeout instance: no ack aborts, ack on the last cycle completes
        mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h0000_3000; mem_wdata = 32'h0;
        tick();
        t_mem_req = 1'b1;
        for (int c = 1; c <= int'(TO_SHORT); c++) begin
            tick();
            @(negedge clk);
            check("to_req", 32'(t_bus_req), 32'd1);
            check("to_no_ack", 32'(t_mem_ack), 32'd0);
            check("to_stall", 32'(t_stall_mem), 32'd1);
        end
        check("to_we", 32'(t_bus_we), 32'd0);
        check("to_sel", 32'(t_bus_sel), 32'hF);
        check("to_addr", t_bus_addr, 32'h0000_3000);
        check("to_wdata", t_bus_wdata, 32'h0);
        tick();
        t_mem_req = 1'b0;
        @(negedge clk);
        check("to_abort_req", 32'(t_bus_req), 32'd0);
        check("to_abort_ack", 32'(t_mem_ack), 32'd1);
        check("to_abort_flag", 32'(t_timeout), 32'd1);
        check("to_abort_data", t_mem_rdata, 32'd0);
        check("to_if_ack", 32'(t_if_ack), 32'd0);
        check("to_stall_if", 32'(t_stall_if), 32'd0);
        tick();
        @(negedge clk);
        check("to_flag_clear", 32'(t_timeout), 32'd0);
        tick();
        t_mem_req = 1'b1;
        for (int c = 1; c <= int'(TO_SHORT); c++) begin
            tick();
            if (c == int'(TO_SHORT)) begin
                t_bus_ack = 1'b1;
                t_rdata   = 32'hCAFE_0004;
            end
        end
        tick();
        t_bus_ack = 1'b0;
        t_rdata   = 32'h0;
        t_mem_req = 1'b0;
        @(negedge clk);
        check("to_edge_ack", 32'(t_mem_ack), 32'd1);
        check("to_edge_flag", 32'(t_timeout), 32'd0);
        check("to_edge_data", t_mem_rdata, 32'hCAFE_0004);
        check("to_if_data", t_if_data, 32'd0);

        tick();
        tick();
        check("end_exp_q", 32'(exp_q.size()), 32'd0);
        check("end_bus_q", 32'(bus_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
